oled_queue: RTL and testbench
=============================

OLED_QUEUE -- requirements
Module: oled_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of FIFO entries; legal values 2, 4, 8, 16.
REQ-002 SHALL have port HCLK  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port HRESETn  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have AHB-Lite slave inputs: HSEL 1, HREADY 1, HWRITE 1, HADDR 32 (bits [3:2] decoded), HWDATA 32, HSIZE 3 (word only, ignored), HTRANS 2.
REQ-005 SHALL have AHB outputs HRDATA 32 (read data) and HREADYOUT 1 (always 1, zero wait states).
REQ-006 SHALL have downstream outputs out_valid 1, out_dnc 1 (0 = command, 1 = data), out_data 16 (word for the OLED serializer).
REQ-007 SHALL have downstream input out_ready 1; the serializer asserts it when idle.

Function
REQ-008 SHALL use this memory map: 0x0 write = push HWDATA[15:0] with dnc=0; 0x4 write = push HWDATA[15:0] with dnc=1; 0x8 read = status; 0xC write = flush.
REQ-009 SHALL register the address phase when HSEL && HREADY && HTRANS!=2'b00, and act in the following data phase using HWDATA or driving HRDATA.
REQ-010 SHALL ignore writes to 0x8, reads of 0x0/0x4/0xC (HRDATA=0), and IDLE transfers.
REQ-011 SHALL store 17-bit entries {dnc, data[15:0]} in a circular buffer with read and write pointers that wrap from DEPTH-1 to 0, plus a count of 0..DEPTH.
REQ-012 SHALL drive out_valid=1 exactly when count>0, with out_dnc/out_data equal to the head entry; when empty, out_dnc=0 and out_data=0.
REQ-013 SHALL pop one entry on each rising edge where out_valid && out_ready; out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-014 SHALL accept a push when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle (count unchanged, both pointers advance).
REQ-015 SHALL drop a push when count==DEPTH and no pop occurs; it SHALL set sticky flag overflow=1 and leave FIFO contents unchanged.
REQ-016 SHALL update count as +1 for push only, -1 for pop only, and unchanged for push+pop; push+pop on an empty FIFO is impossible because out_valid=0.
REQ-017 SHALL, on flush data phase, set count=0, both pointers=0, and overflow=0; flush SHALL win over a same-cycle pop.
REQ-018 SHALL return status in the data phase as HRDATA[4:0]=count, [8]=empty, [9]=full, [16]=overflow, other bits 0, all sampled before that cycle's update.
REQ-019 SHALL give push-to-out_valid latency of 1 cycle: the entry is visible the cycle after the data-phase edge.
REQ-020 SHALL drive HRDATA=0 whenever no status read is in data phase.

Reset
REQ-021 SHALL, while HRESETn=0, force count=0, pointers=0, overflow=0, out_valid=0, out_dnc=0, out_data=0, HRDATA=0, HREADYOUT=1, and clear any pending data phase.
REQ-022 SHALL discard queued entries and an in-flight AHB transfer on reset mid-operation; the first post-reset transfer SHALL behave as from a clean start.
REQ-023 SHALL NOT need storage array contents reset; they are unobservable while count=0.

Verification
REQ-024 SHALL cover: write 0x00AE to 0x0, out_ready=0 -> next cycle out_valid=1, out_dnc=0, out_data=0x00AE; raise out_ready -> popped after 1 edge, out_valid=0.
REQ-025 SHALL cover: push DEPTH=8 words to 0x4 with out_ready=0, then a 9th -> status read =0x0000_0208 before the 9th and 0x0001_0208 after; head still equals the 1st word.
REQ-026 SHALL cover: FIFO full, out_ready=1 during a push data phase -> push accepted, count stays 8, and overflow stays 0.
REQ-027 SHALL cover: 20 interleaved pushes/pops with random out_ready -> output order equals push order across pointer wrap, with dnc preserved per entry.
REQ-028 SHALL cover: 3 queued entries, write 0xC with out_ready=1 -> no pop occurs, status read =0x0000_0100, out_valid=0.
REQ-029 SHALL cover: assert HRESETn=0 mid-push with 5 entries queued -> out_valid=0 immediately (asynchronously); after release, status read =0x0000_0100.

Source files
------------

// File: rtl/oled_queue.sv
// oled_queue: AHB-Lite slave that queues 16-bit command/data words for an OLED
// serializer. Words pushed at 0x0 are commands (dnc=0), at 0x4 are data (dnc=1).
// Status at 0x8 reports count, empty, full and a sticky overflow. A write to 0xC
// flushes the queue. Zero wait states throughout.
module oled_queue #(
    parameter int DEPTH = 8
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic        HWRITE,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        out_valid,
    output logic        out_dnc,
    output logic [15:0] out_data,
    input  logic        out_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          dp_valid_q, dp_valid_d;
    logic          dp_write_q, dp_write_d;
    logic [1:0]    dp_addr_q, dp_addr_d;
    logic [16:0]   mem_q [DEPTH];

    logic empty, full;
    logic push_req, do_push, do_pop, do_flush, st_read;
    logic unused_ok;

    // Only word index bits [3:2] and the low half of write data matter.
    assign unused_ok = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA[31:16]};

    assign empty    = (count_q == '0);
    assign full     = (count_q == DEPTH_C);
    assign push_req = dp_valid_q && dp_write_q && !dp_addr_q[1];
    assign do_flush = dp_valid_q && dp_write_q && (dp_addr_q == 2'b11);
    assign st_read  = dp_valid_q && !dp_write_q && (dp_addr_q == 2'b10);
    // Flush beats a same-cycle pop so the serializer never sees a stale head.
    assign do_pop   = !empty && out_ready && !do_flush;
    // A full queue still takes a push when the head leaves in the same cycle.
    assign do_push  = push_req && (!full || do_pop);

    assign HREADYOUT = 1'b1;
    assign out_valid = !empty;
    assign out_dnc   = empty ? 1'b0  : mem_q[rd_ptr_q][16];
    assign out_data  = empty ? 16'h0 : mem_q[rd_ptr_q][15:0];
    assign HRDATA    = st_read ? {15'h0, overflow_q, 6'h0, full, empty, 3'h0, 5'(count_q)}
                               : 32'h0;

    // Next-state: address-phase capture, pointer/count/overflow updates.
    always_comb begin
        dp_valid_d = HSEL && HREADY && (HTRANS != 2'b00);
        dp_write_d = HWRITE;
        dp_addr_d  = HADDR[3:2];
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (do_flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_d = count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_d = count_q - 1'b1;
            end
            if (push_req && !do_push) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Control state registers with asynchronous active-low reset.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= 2'b00;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            dp_valid_q <= dp_valid_d;
            dp_write_q <= dp_write_d;
            dp_addr_q  <= dp_addr_d;
        end
    end

    // Entry storage; left unreset since it is only visible while count > 0.
    always_ff @(posedge HCLK) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= {dp_addr_q[0], HWDATA[15:0]};
        end
    end

endmodule

// File: tb/tb_oled_queue.sv
// Bench for oled_queue: a vector table of single AHB transfers, hand sequences
// for full/overflow/flush/reset corners, and a randomized run checked every
// cycle against a queue-based reference model.
module tb_oled_queue;

    localparam int DEPTH = 8;

    logic        HCLK, HRESETn, HSEL, HREADY, HWRITE;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic        HREADYOUT, out_valid, out_dnc, out_ready;
    logic [15:0] out_data;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    oled_queue #(.DEPTH(DEPTH)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY),
        .HWRITE(HWRITE), .HADDR(HADDR), .HWDATA(HWDATA), .HSIZE(HSIZE),
        .HTRANS(HTRANS), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
        .out_valid(out_valid), .out_dnc(out_dnc), .out_data(out_data),
        .out_ready(out_ready)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {dnc,data} plus a sticky overflow bit.
    logic [16:0] mq[$];
    bit          m_ov = 0;
    bit          m_dp = 0;
    bit          m_wr = 0;
    logic [1:0]  m_a  = 2'b00;

    always @(posedge HCLK or negedge HRESETn) begin : model
        int sz;
        bit pop;
        if (!HRESETn) begin
            mq.delete();
            m_ov = 0;
            m_dp = 0;
        end else begin
            sz  = mq.size();
            pop = (sz > 0) && out_ready;
            if (m_dp && m_wr && m_a == 2'b11) begin
                mq.delete();
                m_ov = 0;
            end else begin
                if (pop) void'(mq.pop_front());
                if (m_dp && m_wr && m_a < 2'b10) begin
                    if (sz < DEPTH || pop) mq.push_back({m_a[0], HWDATA[15:0]});
                    else m_ov = 1;
                end
            end
            m_dp = HSEL && HREADY && (HTRANS != 2'b00);
            m_wr = HWRITE;
            m_a  = HADDR[3:2];
        end
    end

    function automatic logic [31:0] m_hrdata();
        int sz = mq.size();
        if (!(m_dp && !m_wr && m_a == 2'b10)) return 32'h0;
        return (m_ov ? 32'h1_0000 : 32'h0) + ((sz == DEPTH) ? 32'h200 : 32'h0)
             + ((sz == 0) ? 32'h100 : 32'h0) + 32'(sz);
    endfunction

    // Continuous comparison against the model, away from the active edge.
    always @(negedge HCLK) begin
        if (chk_en && HRESETn) begin
            chk("mon_valid", 32'(out_valid), 32'(mq.size() > 0));
            chk("mon_dnc", 32'(out_dnc), (mq.size() > 0) ? 32'(mq[0][16]) : 32'h0);
            chk("mon_data", 32'(out_data), (mq.size() > 0) ? 32'(mq[0][15:0]) : 32'h0);
            chk("mon_hrdata", HRDATA, m_hrdata());
            chk("mon_hreadyout", 32'(HREADYOUT), 32'h1);
        end
    end

    // One AHB transfer; out_ready = ra during the address cycle, rd during data.
    task automatic xfer(input logic wr, input logic [3:0] a, input logic [31:0] d,
                        input logic ra, input logic rd, output logic [31:0] rdata);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = {28'h0, a}; out_ready = ra;
        @(negedge HCLK);
        rdata = HRDATA;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'h0; HWDATA = d; out_ready = rd;
        @(negedge HCLK);
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic        rdy;
        logic        ev;
        logic        edn;
        logic [15:0] ed;
        logic [31:0] er;
    } vec_t;

    vec_t        tbl[11];
    logic [31:0] rd;
    logic [15:0] exp_words[8];

    initial begin
        tbl[0]  = '{1'b1, 4'h0, 32'h0000_00AE, 1'b0, 1'b1, 1'b0, 16'h00AE, 32'h0};
        tbl[1]  = '{1'b0, 4'h8, 32'h0,         1'b0, 1'b1, 1'b0, 16'h00AE, 32'h0000_0001};
        tbl[2]  = '{1'b1, 4'h4, 32'hABCD_1234, 1'b0, 1'b1, 1'b0, 16'h00AE, 32'h0};
        tbl[3]  = '{1'b0, 4'h8, 32'h0,         1'b0, 1'b1, 1'b0, 16'h00AE, 32'h0000_0002};
        tbl[4]  = '{1'b0, 4'h0, 32'h0,         1'b0, 1'b1, 1'b0, 16'h00AE, 32'h0};
        tbl[5]  = '{1'b1, 4'h8, 32'h0000_FFFF, 1'b0, 1'b1, 1'b0, 16'h00AE, 32'h0};
        tbl[6]  = '{1'b0, 4'h8, 32'h0,         1'b0, 1'b1, 1'b0, 16'h00AE, 32'h0000_0002};
        tbl[7]  = '{1'b1, 4'hC, 32'h0,         1'b0, 1'b0, 1'b0, 16'h0000, 32'h0};
        tbl[8]  = '{1'b0, 4'h8, 32'h0,         1'b0, 1'b0, 1'b0, 16'h0000, 32'h0000_0100};
        tbl[9]  = '{1'b1, 4'h4, 32'h0000_BEEF, 1'b0, 1'b1, 1'b1, 16'hBEEF, 32'h0};
        tbl[10] = '{1'b0, 4'h8, 32'h0,         1'b1, 1'b0, 1'b0, 16'h0000, 32'h0000_0100};

        HRESETn = 1'b0; HSEL = 1'b0; HREADY = 1'b1; HWRITE = 1'b0; HADDR = 32'h0;
        HWDATA = 32'h0; HSIZE = 3'b010; HTRANS = 2'b00; out_ready = 1'b0;
        repeat (2) @(negedge HCLK);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data", 32'(out_data), 32'h0);
        chk("rst_hrdata", HRDATA, 32'h0);
        chk("rst_hreadyout", 32'(HREADYOUT), 32'h1);
        HRESETn = 1'b1;
        chk_en = 1;

        foreach (tbl[i]) begin
            xfer(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].rdy, tbl[i].rdy, rd);
            chk($sformatf("tbl%0d_hrdata", i), rd, tbl[i].er);
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_dnc", i), 32'(out_dnc), 32'(tbl[i].edn));
            chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].ed));
        end

        // Single command, then one edge of out_ready drains it.
        xfer(1'b1, 4'h0, 32'h0000_00AE, 1'b0, 1'b0, rd);
        chk("pop_pre_valid", 32'(out_valid), 32'h1);
        chk("pop_pre_data", 32'(out_data), 32'h00AE);
        out_ready = 1'b1;
        @(posedge HCLK); #1;
        chk("pop_post_valid", 32'(out_valid), 32'h0);
        @(negedge HCLK); out_ready = 1'b0;

        // Fill to DEPTH, then overflow with a ninth data word.
        for (int i = 0; i < DEPTH; i++) xfer(1'b1, 4'h4, 32'h1000 + i, 1'b0, 1'b0, rd);
        xfer(1'b0, 4'h8, 32'h0, 1'b0, 1'b0, rd);
        chk("full_status", rd, 32'h0000_0208);
        xfer(1'b1, 4'h4, 32'h2000, 1'b0, 1'b0, rd);
        xfer(1'b0, 4'h8, 32'h0, 1'b0, 1'b0, rd);
        chk("ovf_status", rd, 32'h0001_0208);
        chk("ovf_head_dnc", 32'(out_dnc), 32'h1);
        chk("ovf_head_data", 32'(out_data), 32'h1000);

        // Flush, refill, then push into a full queue while the head pops.
        xfer(1'b1, 4'hC, 32'h0, 1'b0, 1'b0, rd);
        for (int i = 0; i < DEPTH; i++) xfer(1'b1, 4'h0, 32'h3000 + i, 1'b0, 1'b0, rd);
        xfer(1'b1, 4'h4, 32'h3100, 1'b0, 1'b1, rd);
        xfer(1'b0, 4'h8, 32'h0, 1'b0, 1'b0, rd);
        chk("fullpop_status", rd, 32'h0000_0208);
        for (int i = 0; i < DEPTH - 1; i++) exp_words[i] = 16'(32'h3001 + i);
        exp_words[DEPTH-1] = 16'h3100;
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("drain%0d_data", i), 32'(out_data), 32'(exp_words[i]));
            chk($sformatf("drain%0d_dnc", i), 32'(out_dnc), (i == DEPTH - 1) ? 32'h1 : 32'h0);
            out_ready = 1'b1;
            @(negedge HCLK);
        end
        out_ready = 1'b0;
        chk("drain_empty", 32'(out_valid), 32'h0);

        // Flush with out_ready high: flush wins, nothing is popped.
        for (int i = 0; i < 3; i++) xfer(1'b1, 4'h0, 32'h40 + i, 1'b0, 1'b0, rd);
        xfer(1'b1, 4'hC, 32'h0, 1'b0, 1'b1, rd);
        chk("flush_valid", 32'(out_valid), 32'h0);
        xfer(1'b0, 4'h8, 32'h0, 1'b0, 1'b0, rd);
        chk("flush_status", rd, 32'h0000_0100);

        // Randomized traffic with wrap, overflow and occasional flush.
        for (int c = 0; c < 400; c++) begin
            int r;
            @(negedge HCLK);
            HSEL = ($urandom_range(0, 9) != 0);
            r = $urandom_range(0, 3);
            HTRANS = (r == 0) ? 2'b00 : ((r == 1) ? 2'b11 : 2'b10);
            r = $urandom_range(0, 19);
            HADDR = (r < 9) ? 32'h0 : ((r < 17) ? 32'h4 : ((r < 19) ? 32'h8 : 32'hC));
            HWRITE = (r < 17) ? ($urandom_range(0, 7) != 0) : (r == 19);
            HWDATA = $urandom;
            out_ready = ($urandom_range(0, 2) == 0);
        end
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'h0; out_ready = 1'b0;
        @(negedge HCLK);
        xfer(1'b1, 4'hC, 32'h0, 1'b0, 1'b0, rd);

        // Reset mid-push with five entries queued.
        for (int i = 0; i < 5; i++) xfer(1'b1, 4'h4, 32'h500 + i, 1'b0, 1'b0, rd);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0;
        @(posedge HCLK); #2;
        HRESETn = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_data", 32'(out_data), 32'h0);
        chk("arst_hrdata", HRDATA, 32'h0);
        chk("arst_hreadyout", 32'(HREADYOUT), 32'h1);
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h77;
        @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        xfer(1'b0, 4'h8, 32'h0, 1'b0, 1'b0, rd);
        chk("post_rst_status", rd, 32'h0000_0100);
        chk("post_rst_valid", 32'(out_valid), 32'h0);
        xfer(1'b1, 4'h0, 32'h0000_0055, 1'b0, 1'b0, rd);
        chk("post_rst_push_data", 32'(out_data), 32'h0055);
        chk("post_rst_push_dnc", 32'(out_dnc), 32'h0);
        xfer(1'b0, 4'h8, 32'h0, 1'b0, 1'b0, rd);
        chk("post_rst_push_status", rd, 32'h0000_0001);

        @(negedge HCLK);
        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
